// File: rtl/pim_sched_pkg.sv
// Shared types and helpers for the PIM MAC scheduler.
// State encoding, row index width and a small min helper.
package pim_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

   localparam int PDEPTH_DEF = 256;
   localparam int ROW_IDX_W  = $clog2(PDEPTH_DEF);

   function automatic int unsigned sat_min(
      input int unsigned a,
      input int unsigned b
   );
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/pim_rwl_mask_gen.sv
// Contiguous read word-line mask: bits [base, base + n) set.
// Purely combinational; caller guarantees base + n <= PDEPTH.
module pim_rwl_mask_gen
   import pim_sched_pkg::*;
#(
   parameter int PDEPTH = PDEPTH_DEF,
   parameter int RIW    = $clog2(PDEPTH)
) (
   input  logic [RIW-1:0]    base,
   input  logic [RIW:0]      n,
   output logic [PDEPTH-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < PDEPTH; i++) begin
         mask[i] = (i >= int'(base)) &&
                   (i < int'(base) + int'(n));
      end
   end

endmodule

// File: rtl/pim_mac_scheduler.sv
// Multi-pass MAC sequencer for the PIM macro, sharing its
// single port between host accesses and compute passes.
module pim_mac_scheduler
   import pim_sched_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int PDEPTH       = 256,
   parameter int MAX_ROWS     = 64,
   parameter int PIM_LATENCY  = 1,
   parameter int ACC_WIDTH    = 48,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [$clog2(PDEPTH)-1:0]  cmd_row_base,
   input  logic [$clog2(PDEPTH):0]    cmd_row_count,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ACC_WIDTH-1:0]       rsp_acc,
   output logic [7:0]                 rsp_passes,
   output logic                       rsp_err,
   input  logic                       host_wr_en,
   input  logic                       host_rd_en,
   input  logic [ADDR_WIDTH-1:0]      host_addr,
   output logic                       host_ready,
   output logic [ADDR_WIDTH-1:0]      pim_addr,
   output logic                       pim_w_en,
   output logic                       pim_p_en,
   output logic [PDEPTH-1:0]          pim_rwl,
   input  logic [DATA_WIDTH-1:0]      pim_mac_out,
   output logic                       busy
);

   localparam int RIW = $clog2(PDEPTH);
   localparam int CW  = RIW + 1;
   localparam int SW  = $clog2(STARVE_LIMIT + 1);

   state_e               state, state_nxt;
   logic [CW-1:0]        cur, rem;
   logic [CW-1:0]        avail, rem_new;
   logic [CW-1:0]        mg_rem, mg_n;
   logic [RIW-1:0]       mg_base;
   logic [PDEPTH-1:0]    mask;
   logic [ACC_WIDTH-1:0] acc, mac_ext;
   logic [7:0]           passes;
   logic                 err;
   logic [SW-1:0]        starve_cnt;
   logic [3:0]           wait_cnt;
   logic                 host_req, compute_win, wait_done;

   assign avail   = CW'(PDEPTH) - {1'b0, cmd_row_base};
   assign rem_new = CW'(sat_min(32'(cmd_row_count), 32'(avail)));

   // Idle builds the first mask from the command; later passes from cur/rem.
   assign mg_base = (state == S_IDLE) ? cmd_row_base : cur[RIW-1:0];
   assign mg_rem  = (state == S_IDLE) ? rem_new : rem;
   assign mg_n    = CW'(sat_min(32'(mg_rem), unsigned'(MAX_ROWS)));

   pim_rwl_mask_gen #(
      .PDEPTH (PDEPTH),
      .RIW    (RIW)
   ) u_mask (
      .base (mg_base),
      .n    (mg_n),
      .mask (mask)
   );

   assign mac_ext   = ACC_WIDTH'($signed(pim_mac_out));
   assign wait_done = (wait_cnt == 4'd1);
   assign host_req  = host_wr_en | host_rd_en;

   assign rsp_valid  = (state == S_RESP);
   assign rsp_acc    = acc;
   assign rsp_passes = passes;
   assign rsp_err    = err;
   assign busy       = (state != S_IDLE);
   assign cmd_ready  = (state == S_IDLE) & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      compute_win = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid)
               state_nxt = (rem_new == '0) ? S_RESP : S_ISSUE;
         end
         S_ISSUE: begin
            compute_win = !host_req ||
                          (starve_cnt == SW'(STARVE_LIMIT));
            if (compute_win) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (wait_done)
               state_nxt = (rem == '0) ? S_RESP : S_ISSUE;
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      pim_p_en   = compute_win;
      host_ready = !compute_win;
      pim_w_en   = host_wr_en & host_ready;
      pim_addr   = host_ready ? host_addr : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur        <= '0;
         rem        <= '0;
         acc        <= '0;
         passes     <= '0;
         err        <= 1'b0;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         pim_rwl    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  cur        <= {1'b0, cmd_row_base};
                  rem        <= rem_new;
                  err        <= (cmd_row_count > avail);
                  acc        <= '0;
                  passes     <= '0;
                  starve_cnt <= '0;
                  if (rem_new != '0) pim_rwl <= mask;
               end
            end
            S_ISSUE: begin
               if (compute_win) begin
                  starve_cnt <= '0;
                  cur        <= cur + mg_n;
                  rem        <= rem - mg_n;
                  wait_cnt   <= 4'(PIM_LATENCY);
               end else begin
                  starve_cnt <= starve_cnt + SW'(1);
               end
            end
            S_WAIT: begin
               if (wait_done) begin
                  acc     <= acc + mac_ext;
                  passes  <= passes + 8'd1;
                  pim_rwl <= (rem != '0) ? mask : '0;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: pim_rwl <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pim_mac_scheduler.sv
// Scoreboard bench for pim_mac_scheduler: directed commands,
// expected masks/responses queued, negedge monitor compares.
module tb_pim_mac_scheduler;

   localparam int DW   = 32;
   localparam int AW   = 8;
   localparam int PD   = 256;
   localparam int RIW  = 8;
   localparam int ACCW = 48;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [RIW-1:0]  cmd_row_base = '0;
   logic [RIW:0]    cmd_row_count = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [ACCW-1:0] rsp_acc;
   logic [7:0]      rsp_passes;
   logic            rsp_err;
   logic            host_wr_en = 1'b0;
   logic            host_rd_en = 1'b0;
   logic [AW-1:0]   host_addr = '0;
   logic            host_ready;
   logic [AW-1:0]   pim_addr;
   logic            pim_w_en;
   logic            pim_p_en;
   logic [PD-1:0]   pim_rwl;
   logic [DW-1:0]   pim_mac_out = '0;
   logic            busy;

   pim_mac_scheduler #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .PDEPTH       (PD),
      .MAX_ROWS     (64),
      .PIM_LATENCY  (1),
      .ACC_WIDTH    (ACCW),
      .STARVE_LIMIT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_row_base  (cmd_row_base),
      .cmd_row_count (cmd_row_count),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_acc       (rsp_acc),
      .rsp_passes    (rsp_passes),
      .rsp_err       (rsp_err),
      .host_wr_en    (host_wr_en),
      .host_rd_en    (host_rd_en),
      .host_addr     (host_addr),
      .host_ready    (host_ready),
      .pim_addr      (pim_addr),
      .pim_w_en      (pim_w_en),
      .pim_p_en      (pim_p_en),
      .pim_rwl       (pim_rwl),
      .pim_mac_out   (pim_mac_out),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ACCW-1:0] acc;
      logic [7:0]      passes;
      logic            err;
   } rsp_t;

   rsp_t          exp_rsp_q[$];
   logic [PD-1:0] exp_mask_q[$];
   logic [DW-1:0] mac_q[$];

   int errors = 0;
   int checks = 0;
   int pen_cnt = 0;

   task automatic chk(input string name,
                      input logic [PD-1:0] got,
                      input logic [PD-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, exp);
      end
   endtask

   task automatic push_mask(input int lo, input int n);
      logic [PD-1:0] m;
      m = '0;
      for (int i = lo; i < lo + n; i++) m[i] = 1'b1;
      exp_mask_q.push_back(m);
   endtask

   task automatic push_rsp(input logic [ACCW-1:0] a,
                           input logic [7:0] p,
                           input logic e);
      rsp_t r;
      r.acc    = a;
      r.passes = p;
      r.err    = e;
      exp_rsp_q.push_back(r);
   endtask

   // Macro model: p_en at an edge puts the next result on mac_out.
   always @(posedge clk) begin
      if (pim_p_en) begin
         pen_cnt++;
         if (mac_q.size() > 0) pim_mac_out <= mac_q.pop_front();
      end
   end

   always @(negedge clk) begin
      if (pim_p_en) begin
         if (exp_mask_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p_en_unexpected got=1 want=0");
         end else begin
            chk("rwl_mask", pim_rwl, exp_mask_q.pop_front());
         end
      end
      if (rsp_valid && rsp_ready) begin
         if (exp_rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected got=1 want=0");
         end else begin
            rsp_t e;
            e = exp_rsp_q.pop_front();
            chk("rsp_acc", rsp_acc, e.acc);
            chk("rsp_passes", rsp_passes, e.passes);
            chk("rsp_err", rsp_err, e.err);
         end
      end
   end

   task automatic send_cmd(input int base, input int count);
      int n;
      @(negedge clk);
      cmd_valid     = 1'b1;
      cmd_row_base  = RIW'(base);
      cmd_row_count = (RIW+1)'(count);
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL cmd_accept_timeout got=0 want=1");
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_rsp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_rsp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout got=%0d want=0 pending",
                  exp_rsp_q.size());
         exp_rsp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      int p0, n, lat, bad;
      logic [5:0] hr, pe;
      logic [AW-1:0] a_grant, a_comp;

      // Reset state
      #12;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_host_ready", host_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rwl", pim_rwl, 0);
      @(negedge clk);
      rst = 1'b1;

      // Single full pass
      mac_q.push_back(32'd100);
      push_mask(0, 64);
      push_rsp(48'd100, 8'd1, 1'b0);
      send_cmd(0, 64);
      wait_drain();

      // Three passes with signed results
      mac_q.push_back(32'd5);
      mac_q.push_back(32'hFFFF_FFFD);
      mac_q.push_back(32'd7);
      push_mask(10, 64);
      push_mask(74, 64);
      push_mask(138, 22);
      push_rsp(48'd9, 8'd3, 1'b0);
      send_cmd(10, 150);
      wait_drain();

      // Clipped range at the top of the array
      mac_q.push_back(32'd11);
      push_mask(250, 6);
      push_rsp(48'd11, 8'd1, 1'b1);
      send_cmd(250, 20);
      wait_drain();

      // Zero-row command: no compute, fast response
      p0 = pen_cnt;
      push_rsp(48'd0, 8'd0, 1'b0);
      send_cmd(5, 0);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("zero_cnt_latency_le2", (lat <= 2), 1);
      wait_drain();
      chk("zero_cnt_no_p_en", pen_cnt - p0, 0);

      // Write has precedence over read
      @(negedge clk);
      host_wr_en = 1'b1;
      host_rd_en = 1'b1;
      host_addr  = 8'hA5;
      #1;
      chk("wr_prec_w_en", pim_w_en, 1);
      chk("wr_prec_addr", pim_addr, 8'hA5);
      host_wr_en = 1'b0;

      // Starvation guard with reads held high
      host_addr = 8'h3C;
      mac_q.push_back(32'd1);
      push_mask(0, 1);
      push_rsp(48'd1, 8'd1, 1'b0);
      send_cmd(0, 1);
      a_grant = '0;
      a_comp  = '1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         hr[k] = host_ready;
         pe[k] = pim_p_en;
         if (k == 0) a_grant = pim_addr;
         if (k == 4) a_comp  = pim_addr;
      end
      chk("starve_host_ready_seq", hr, 6'b101111);
      chk("starve_p_en_seq", pe, 6'b010000);
      chk("starve_grant_addr", a_grant, 8'h3C);
      chk("starve_compute_addr", a_comp, 0);
      host_rd_en = 1'b0;
      wait_drain();

      // Response backpressure
      rsp_ready = 1'b0;
      mac_q.push_back(32'd42);
      push_mask(0, 64);
      push_rsp(48'd42, 8'd1, 1'b0);
      send_cmd(0, 64);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_acc != 48'd42 ||
             rsp_passes != 8'd1 || cmd_ready) bad++;
      end
      chk("bp_unstable_cycles", bad, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      rsp_ready = 1'b1;
      wait_drain();

      // Reset during the second pass's WAIT
      mac_q.push_back(32'd5);
      mac_q.push_back(32'hFFFF_FFFD);
      push_mask(0, 64);
      push_mask(64, 64);
      p0 = pen_cnt;
      send_cmd(0, 150);
      n = 0;
      while (pen_cnt < p0 + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_reached_pass2", pen_cnt - p0, 2);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_acc", rsp_acc, 0);
      chk("rst_mid_passes", rsp_passes, 0);
      chk("rst_mid_rwl", pim_rwl, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 0);
      mac_q.delete();
      exp_mask_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Normal operation after reset
      mac_q.push_back(32'd5);
      mac_q.push_back(32'hFFFF_FFFD);
      mac_q.push_back(32'd7);
      push_mask(10, 64);
      push_mask(74, 64);
      push_mask(138, 22);
      push_rsp(48'd9, 8'd3, 1'b0);
      send_cmd(10, 150);
      wait_drain();

      chk("mask_q_drained", exp_mask_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
